// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes and
// the ALU operand/operation select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that touch the single-port memory and may be stretched by MEM_WAIT
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Down-counter that stretches memory states: reloaded with MEM_WAIT while
// idle, counts down while a memory state waits, done when it reaches zero.
module mc_wait_counter #(
  parameter int MEM_WAIT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam logic [3:0] WAIT_INIT = MEM_WAIT[3:0];

  logic [3:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= WAIT_INIT;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared-memory datapath (R-format, lw, sw,
// beq) with a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic             pc_src,
  output logic             iord,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  state_t state_q;
  logic   wait_done;
  logic   wait_load;

  // Keep the counter primed unless a memory state is still waiting, so every
  // entry into FETCH/MEMRD/MEMWR starts with a fresh MEM_WAIT count.
  assign wait_load = !is_mem_state(state_q) || wait_done;

  mc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (wait_done) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            default: begin
              state_q <= S_HALT;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (wait_done) state_q <= S_MEMWB;
        S_MEMWR: begin
          if (wait_done) begin
            state_q     <= S_FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        S_MEMWB, S_ALUWB, S_BRANCH: begin
          state_q     <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        S_EXEC:   state_q <= S_ALUWB;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on the current state (plus the FETCH end-of-wait and
  // the branch zero flag), so reset forces them all low immediately.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_ren   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_ren = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_wen = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = alu_zero;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with MEM_WAIT=2: per-cycle state
// and control-vector checks for each instruction class, halt and reset.
module tb_multicycle_controller;

  localparam int W = 2;

  // {pc_write,pc_src,iord,mem_ren,mem_wen,ir_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,alu_op}
  localparam logic [13:0] C_ZERO       = 14'b0_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_FETCH      = 14'b0_0_0_1_0_0_0_0_0_0_01_00;
  localparam logic [13:0] C_FETCH_LAST = 14'b1_0_0_1_0_1_0_0_0_0_01_00;
  localparam logic [13:0] C_DECODE     = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [13:0] C_MEMADR     = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [13:0] C_MEMRD      = 14'b0_0_1_1_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_MEMWB      = 14'b0_0_0_0_0_0_1_0_1_0_00_00;
  localparam logic [13:0] C_MEMWR      = 14'b0_0_1_0_1_0_0_0_0_0_00_00;
  localparam logic [13:0] C_EXEC       = 14'b0_0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [13:0] C_ALUWB      = 14'b0_0_0_0_0_0_1_1_0_0_00_00;
  localparam logic [13:0] C_BEQ_TAKEN  = 14'b1_1_0_0_0_0_0_0_0_1_00_01;
  localparam logic [13:0] C_BEQ_NOT    = 14'b0_1_0_0_0_0_0_0_0_1_00_01;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        pc_write, pc_src, iord, mem_ren, mem_wen, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic        illegal;
  logic [13:0] ctl;

  int check_count = 0;
  int fail_count  = 0;

  multicycle_controller #(.MEM_WAIT(W), .CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .state       (state),
    .instr_count (instr_count),
    .illegal     (illegal)
  );

  assign ctl = {pc_write, pc_src, iord, mem_ren, mem_wen, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic zero);
    opcode   = op;
    alu_zero = zero;
  endtask

  // Check the current cycle (called at a negedge), then advance one cycle
  task automatic expectCycle(input string tag, input logic [3:0] exp_state,
                             input logic [13:0] exp_ctl);
    checkOutput({tag, "_state"}, 32'(state), 32'(exp_state));
    checkOutput({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    @(negedge clock);
  endtask

  task automatic fetchPhase(input string tag);
    for (int i = 0; i < W; i++) expectCycle({tag, "_fetch"}, 4'd1, C_FETCH);
    expectCycle({tag, "_fetch_last"}, 4'd1, C_FETCH_LAST);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(6'd0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_ctl", 32'(ctl), 32'(C_ZERO));
      checkOutput("rst_count", instr_count, 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // R-format: FETCH x3, DECODE, EXEC, ALUWB
    applyStimulus(6'd0, 1'b0);
    fetchPhase("r");
    expectCycle("r_decode", 4'd2, C_DECODE);
    expectCycle("r_exec", 4'd7, C_EXEC);
    expectCycle("r_aluwb", 4'd8, C_ALUWB);
    checkOutput("r_count", instr_count, 32'd1);

    // lw: FETCH x3, DECODE, MEMADR, MEMRD x3, MEMWB
    applyStimulus(6'd35, 1'b0);
    fetchPhase("lw");
    expectCycle("lw_decode", 4'd2, C_DECODE);
    expectCycle("lw_memadr", 4'd3, C_MEMADR);
    for (int i = 0; i <= W; i++) expectCycle("lw_memrd", 4'd4, C_MEMRD);
    expectCycle("lw_memwb", 4'd5, C_MEMWB);
    checkOutput("lw_count", instr_count, 32'd2);

    // sw: FETCH x3, DECODE, MEMADR, MEMWR x3
    applyStimulus(6'd43, 1'b0);
    fetchPhase("sw");
    expectCycle("sw_decode", 4'd2, C_DECODE);
    expectCycle("sw_memadr", 4'd3, C_MEMADR);
    for (int i = 0; i <= W; i++) expectCycle("sw_memwr", 4'd6, C_MEMWR);
    checkOutput("sw_count", instr_count, 32'd3);

    applyStimulus(6'd4, 1'b1);
    fetchPhase("beq_t");
    expectCycle("beq_t_decode", 4'd2, C_DECODE);
    expectCycle("beq_t_branch", 4'd9, C_BEQ_TAKEN);
    checkOutput("beq_t_count", instr_count, 32'd4);

    applyStimulus(6'd4, 1'b0);
    fetchPhase("beq_n");
    expectCycle("beq_n_decode", 4'd2, C_DECODE);
    expectCycle("beq_n_branch", 4'd9, C_BEQ_NOT);
    checkOutput("beq_n_count", instr_count, 32'd5);
    checkOutput("pre_halt_illegal", 32'(illegal), 32'd0);

    // Unsupported opcode parks in HALT with the sticky flag
    applyStimulus(6'd2, 1'b1);
    fetchPhase("ill");
    expectCycle("ill_decode", 4'd2, C_DECODE);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_illegal", 32'(illegal), 32'd1);
      expectCycle("halt", 4'd15, C_ZERO);
    end
    checkOutput("halt_count", instr_count, 32'd5);

    reset = 1'b0;
    #1;
    checkOutput("halt_rst_state", 32'(state), 32'd0);
    checkOutput("halt_rst_illegal", 32'(illegal), 32'd0);
    checkOutput("halt_rst_count", instr_count, 32'd0);
    checkOutput("halt_rst_ctl", 32'(ctl), 32'(C_ZERO));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset in the middle of a store must drop mem_wen at once
    applyStimulus(6'd43, 1'b0);
    fetchPhase("abort");
    expectCycle("abort_decode", 4'd2, C_DECODE);
    expectCycle("abort_memadr", 4'd3, C_MEMADR);
    checkOutput("abort_memwr_ctl", 32'(ctl), 32'(C_MEMWR));
    reset = 1'b0;
    #1;
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_ctl", 32'(ctl), 32'(C_ZERO));
    @(negedge clock);
    checkOutput("abort_hold_ctl", 32'(ctl), 32'(C_ZERO));
    reset = 1'b1;
    @(negedge clock);
    expectCycle("post_abort_fetch", 4'd1, C_FETCH);
    checkOutput("post_abort_count", instr_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
